ex_mem_skid: RTL and testbench

- Elastic EX/MEM pipeline stage of the 5-stage RV32 core. It sits directly downstream of the execute-stage ALU.
- It captures the ALU result, the zero flag, store data, destination register and memory/writeback controls, then presents them to the memory stage.
- A two-entry skid buffer lets a memory-stage stall back-pressure execute without a combinational ready path.
- It also resolves conditional branches from the ALU zero flag and emits a registered redirect.

---
 rtl/ex_mem_skid.sv | 134 +++++++++++++
 tb/tb_ex_mem_skid.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid.sv
// EX/MEM elastic pipeline stage: two-entry skid buffer between execute and memory,
// with branch resolution on the ALU zero flag and a registered one-cycle redirect.
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_branch,
  input  logic [DATA_W-1:0] ex_branch_target,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sd;
    logic [REG_W-1:0]  rd;
    logic              rw;
    logic              mr;
    logic              mw;
  } beat_t;

  state_t            state_q, state_d;
  beat_t             main_q, main_d, skid_q, skid_d, in_beat;
  logic              mem_valid_q, mem_valid_d;
  logic              ex_ready_q, ex_ready_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_target_q, br_target_d;
  logic              accept, drain;

  assign accept = ex_valid & ex_ready_q;
  assign drain  = mem_valid_q & mem_ready;

  // x0 is hardwired zero, so a write to it is squashed at capture
  assign in_beat = '{alu: ex_alu_out, sd: ex_store_data, rd: ex_rd,
                     rw: ex_reg_write & (ex_rd != '0),
                     mr: ex_mem_read, mw: ex_mem_write};

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      if (accept && ex_branch && ex_zero) begin
        br_taken_d  = 1'b1;
        br_target_d = ex_branch_target;
      end
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = in_beat;
          end else if (accept) begin
            skid_d  = in_beat;
            state_d = TWO;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    mem_valid_d = (state_d != EMPTY);
    ex_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      mem_valid_q <= 1'b0;
      ex_ready_q  <= 1'b1;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      mem_valid_q <= mem_valid_d;
      ex_ready_q  <= ex_ready_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign ex_ready       = ex_ready_q;
  assign mem_valid      = mem_valid_q;
  assign mem_alu_out    = main_q.alu;
  assign mem_store_data = main_q.sd;
  assign mem_rd         = main_q.rd;
  assign mem_reg_write  = main_q.rw;
  assign mem_mem_read   = main_q.mr;
  assign mem_mem_write  = main_q.mw;
  assign branch_taken   = br_taken_q;
  assign branch_target  = br_target_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: streaming, back-pressure, branch, x0, flush, async reset.
module tb_ex_mem_skid;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset, flush, ex_valid, ex_ready, ex_zero;
  logic [DATA_W-1:0] ex_alu_out, ex_store_data, ex_branch_target;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic              mem_valid, mem_ready;
  logic [DATA_W-1:0] mem_alu_out, mem_store_data, branch_target;
  logic [REG_W-1:0]  mem_rd;
  logic              mem_reg_write, mem_mem_read, mem_mem_write, branch_taken;

  int pass_cnt = 0;
  int total_cnt = 0;

  ex_mem_skid #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_zero(ex_zero), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_branch_target(ex_branch_target),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic [DATA_W-1:0] alu,
                          input logic [REG_W-1:0] rd, input logic rw,
                          input logic br, input logic z, input logic [DATA_W-1:0] tgt);
    ex_valid = v; ex_alu_out = alu; ex_store_data = alu ^ 32'hA5A5_0000;
    ex_rd = rd; ex_reg_write = rw; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_branch = br; ex_zero = z; ex_branch_target = tgt;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    set_beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    step();
    total_cnt++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid got %0b want 0", mem_valid); else pass_cnt++;
    total_cnt++; if (ex_ready !== 1'b1) $display("FAIL rst_ex_ready got %0b want 1", ex_ready); else pass_cnt++;
    total_cnt++; if (branch_taken !== 1'b0) $display("FAIL rst_branch_taken got %0b want 0", branch_taken); else pass_cnt++;
    total_cnt++; if (mem_alu_out !== 32'h0 || branch_target !== 32'h0 || mem_rd !== 5'd0)
      $display("FAIL rst_data alu=%h tgt=%h rd=%0d want 0", mem_alu_out, branch_target, mem_rd); else pass_cnt++;
    reset = 1'b0;
    step();
    total_cnt++; if (ex_ready !== 1'b1 || mem_valid !== 1'b0)
      $display("FAIL post_rst ex_ready=%0b mem_valid=%0b want 1/0", ex_ready, mem_valid); else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] exp;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h11 * (i + 1);
      set_beat(1'b1, exp, 5'd1, 1'b1, 1'b0, 1'b0, '0);
      step();
      total_cnt++; if (mem_valid !== 1'b1 || mem_alu_out !== exp || ex_ready !== 1'b1)
        $display("FAIL stream_%0d valid=%0b alu=%h rdy=%0b want 1/%h/1", i, mem_valid, mem_alu_out, ex_ready, exp); else pass_cnt++;
      total_cnt++; if (mem_store_data !== (exp ^ 32'hA5A5_0000))
        $display("FAIL stream_sd_%0d got %h want %h", i, mem_store_data, exp ^ 32'hA5A5_0000); else pass_cnt++;
    end
    ex_valid = 1'b0;
    step();
    total_cnt++; if (mem_valid !== 1'b0) $display("FAIL stream_drain valid got %0b want 0", mem_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    set_beat(1'b1, 32'hA, 5'd2, 1'b1, 1'b0, 1'b0, '0);
    step();
    total_cnt++; if (mem_alu_out !== 32'hA || ex_ready !== 1'b1)
      $display("FAIL bp_first alu=%h rdy=%0b want a/1", mem_alu_out, ex_ready); else pass_cnt++;
    set_beat(1'b1, 32'hB, 5'd3, 1'b1, 1'b0, 1'b0, '0);
    step();
    total_cnt++; if (mem_alu_out !== 32'hA || ex_ready !== 1'b0 || mem_valid !== 1'b1)
      $display("FAIL bp_full alu=%h rdy=%0b valid=%0b want a/0/1", mem_alu_out, ex_ready, mem_valid); else pass_cnt++;
    ex_valid = 1'b0;
    step();
    total_cnt++; if (mem_alu_out !== 32'hA || mem_rd !== 5'd2 || ex_ready !== 1'b0)
      $display("FAIL bp_hold alu=%h rd=%0d rdy=%0b want a/2/0", mem_alu_out, mem_rd, ex_ready); else pass_cnt++;
    mem_ready = 1'b1;
    step();
    total_cnt++; if (mem_alu_out !== 32'hB || mem_rd !== 5'd3 || ex_ready !== 1'b1 || mem_valid !== 1'b1)
      $display("FAIL bp_drain_a alu=%h rd=%0d rdy=%0b valid=%0b want b/3/1/1", mem_alu_out, mem_rd, ex_ready, mem_valid); else pass_cnt++;
    step();
    total_cnt++; if (mem_valid !== 1'b0) $display("FAIL bp_drain_b valid got %0b want 0", mem_valid); else pass_cnt++;
  endtask

  task automatic test_branch();
    mem_ready = 1'b1;
    set_beat(1'b1, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
    step();
    total_cnt++; if (branch_taken !== 1'b1 || branch_target !== 32'h100)
      $display("FAIL br_taken taken=%0b tgt=%h want 1/100", branch_taken, branch_target); else pass_cnt++;
    ex_valid = 1'b0;
    step();
    total_cnt++; if (branch_taken !== 1'b0 || branch_target !== 32'h100)
      $display("FAIL br_pulse taken=%0b tgt=%h want 0/100", branch_taken, branch_target); else pass_cnt++;
    set_beat(1'b1, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0200);
    step();
    total_cnt++; if (branch_taken !== 1'b0 || branch_target !== 32'h100)
      $display("FAIL br_not_taken taken=%0b tgt=%h want 0/100", branch_taken, branch_target); else pass_cnt++;
    ex_valid = 1'b0;
    step();
  endtask

  task automatic test_x0();
    mem_ready = 1'b1;
    set_beat(1'b1, 32'h77, 5'd0, 1'b1, 1'b0, 1'b0, '0);
    step();
    total_cnt++; if (mem_reg_write !== 1'b0 || mem_rd !== 5'd0 || mem_valid !== 1'b1)
      $display("FAIL x0_suppress rw=%0b rd=%0d valid=%0b want 0/0/1", mem_reg_write, mem_rd, mem_valid); else pass_cnt++;
    set_beat(1'b1, 32'h78, 5'd5, 1'b1, 1'b0, 1'b0, '0);
    ex_mem_read = 1'b1; ex_mem_write = 1'b1;
    step();
    total_cnt++; if (mem_reg_write !== 1'b1 || mem_rd !== 5'd5)
      $display("FAIL x5_write rw=%0b rd=%0d want 1/5", mem_reg_write, mem_rd); else pass_cnt++;
    total_cnt++; if (mem_mem_read !== 1'b1 || mem_mem_write !== 1'b1)
      $display("FAIL mem_ctrl mr=%0b mw=%0b want 1/1", mem_mem_read, mem_mem_write); else pass_cnt++;
    ex_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    set_beat(1'b1, 32'h21, 5'd1, 1'b1, 1'b0, 1'b0, '0);
    step();
    set_beat(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, '0);
    step();
    total_cnt++; if (ex_ready !== 1'b0) $display("FAIL fl_two rdy got %0b want 0", ex_ready); else pass_cnt++;
    flush = 1'b1;
    set_beat(1'b1, 32'h23, 5'd3, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
    step();
    total_cnt++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1 || branch_taken !== 1'b0 || branch_target !== 32'h100)
      $display("FAIL fl_kill valid=%0b rdy=%0b taken=%0b tgt=%h want 0/1/0/100", mem_valid, ex_ready, branch_taken, branch_target); else pass_cnt++;
    flush = 1'b0;
    set_beat(1'b1, 32'h55, 5'd4, 1'b1, 1'b0, 1'b0, '0);
    step();
    total_cnt++; if (mem_valid !== 1'b1 || mem_alu_out !== 32'h55 || ex_ready !== 1'b1)
      $display("FAIL fl_resume valid=%0b alu=%h rdy=%0b want 1/55/1", mem_valid, mem_alu_out, ex_ready); else pass_cnt++;
    ex_valid = 1'b0; mem_ready = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    mem_ready = 1'b0;
    set_beat(1'b1, 32'h66, 5'd6, 1'b1, 1'b0, 1'b0, '0);
    step();
    set_beat(1'b1, 32'h67, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0400);
    step();
    total_cnt++; if (branch_taken !== 1'b1 || ex_ready !== 1'b0 || branch_target !== 32'h400)
      $display("FAIL ar_setup taken=%0b rdy=%0b tgt=%h want 1/0/400", branch_taken, ex_ready, branch_target); else pass_cnt++;
    ex_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (mem_valid !== 1'b0 || branch_taken !== 1'b0 || ex_ready !== 1'b1)
      $display("FAIL ar_immediate valid=%0b taken=%0b rdy=%0b want 0/0/1", mem_valid, branch_taken, ex_ready); else pass_cnt++;
    total_cnt++; if (mem_alu_out !== 32'h0 || branch_target !== 32'h0)
      $display("FAIL ar_data alu=%h tgt=%h want 0/0", mem_alu_out, branch_target); else pass_cnt++;
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    set_beat(1'b1, 32'h99, 5'd7, 1'b1, 1'b0, 1'b0, '0);
    step();
    total_cnt++; if (mem_valid !== 1'b1 || mem_alu_out !== 32'h99)
      $display("FAIL ar_resume valid=%0b alu=%h want 1/99", mem_valid, mem_alu_out); else pass_cnt++;
    ex_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_branch();
    test_x0();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
